// File: rtl/gessm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gessm_mul_arbiter
// Brief    : Round-robin front end sharing one approximate segmented 16x16
//            multiplier (10x10 core) between NREQ requesters; 2-stage pipe.
// Revision : 1.0 - initial release
// ============================================================================
module gessm_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy
);

    typedef struct packed {
        logic [9:0] seg;
        logic [2:0] sh;
    } seg_t;

    // Keep the ten most significant useful bits; the shift restores magnitude.
    function automatic seg_t segment(input logic [15:0] x);
        seg_t s;
        if (x[15]) begin
            s.seg = x[15:6];
            s.sh  = 3'd6;
        end else if (x[14:10] != 5'd0) begin
            s.seg = x[14:5];
            s.sh  = 3'd5;
        end else begin
            s.seg = x[9:0];
            s.sh  = 3'd0;
        end
        return s;
    endfunction

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [9:0]      r_s1_seg_a;
    logic [9:0]      r_s1_seg_b;
    logic [3:0]      r_s1_sh;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_valid;
    logic [31:0]     r_res_data;
    logic [ID_W-1:0] r_res_id;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_found;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_cand;
    logic            w_hs;
    logic [15:0]     w_op_a;
    logic [15:0]     w_op_b;
    seg_t            w_seg_a;
    seg_t            w_seg_b;
    logic [19:0]     w_mul;
    logic [31:0]     w_prod;

    assign w_s2_adv = !r_s2_valid || res_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_hs = w_found && w_s1_adv && !rst;

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_op_a  = req_a[{w_grant, 4'b0000} +: 16];
    assign w_op_b  = req_b[{w_grant, 4'b0000} +: 16];
    assign w_seg_a = segment(w_op_a);
    assign w_seg_b = segment(w_op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_seg_a <= '0;
            r_s1_seg_b <= '0;
            r_s1_sh    <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_seg_a <= w_seg_a.seg;
                r_s1_seg_b <= w_seg_b.seg;
                r_s1_sh    <= {1'b0, w_seg_a.sh} + {1'b0, w_seg_b.sh};
                r_s1_id    <= w_grant;
                r_ptr      <= (w_grant == ID_W'(NREQ - 1)) ? '0 : w_grant + ID_W'(1);
            end
        end
    end

    // Largest case 0x3FF*0x3FF<<12 still fits in 32 bits.
    assign w_mul  = {10'b0, r_s1_seg_a} * {10'b0, r_s1_seg_b};
    assign w_prod = {12'b0, w_mul} << r_s1_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res_data <= '0;
            r_res_id   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_data <= w_prod;
                r_res_id   <= r_s1_id;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_gessm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gessm_mul_arbiter
// Brief    : Directed stimulus with a handshake-driven scoreboard for
//            gessm_mul_arbiter; expected products are hand-computed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gessm_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_id;
    logic        busy;

    gessm_mul_arbiter #(.NREQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e;
    } req_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  id;
        int          cyc;
    } sb_t;

    req_t        pend[$];
    sb_t         sb[$];
    int          grant_q[$];
    logic [3:0]  v;
    logic [15:0] ta[4];
    logic [15:0] tb_b[4];
    logic [31:0] cur_exp[4];
    logic [3:0]  hs_mask;
    logic        lat_chk;
    int          n_chk;
    int          n_pass;
    int          cyc;

    assign req_valid = v;
    assign req_a     = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b     = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        logic [3:0] hs;
        logic       stall;
        logic [31:0] held_d;
        logic [1:0]  held_id;
        sb_t         e;
        int          g;
        stall = 1'b0;
        held_d = '0;
        held_id = '0;
        hs_mask = '0;
        cyc = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                sb.delete();
                hs_mask = '0;
                stall = 1'b0;
            end else begin
                hs = req_valid & req_ready;
                hs_mask = hs;
                if (req_ready != 4'b0) chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (hs[i]) begin
                        sb.push_back('{d: cur_exp[i], id: 2'(i), cyc: cyc});
                        if (grant_q.size() > 0) begin
                            g = grant_q.pop_front();
                            chk("grant_order", 32'(i), 32'(g));
                        end
                    end
                end
                if (stall) begin
                    chk("hold_valid", 32'(res_valid), 32'd1);
                    chk("hold_data", res_data, held_d);
                    chk("hold_id", 32'(res_id), 32'(held_id));
                end
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'(res_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_data", res_data, e.d);
                        chk("res_id", 32'(res_id), 32'(e.id));
                        if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    end
                end
                stall   = res_valid && !res_ready;
                held_d  = res_data;
                held_id = res_id;
            end
            cyc++;
        end
    end

    // Advance one clock; retire accepted operands and load queued ones.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs_mask[i]) v[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
                for (int k = 0; k < pend.size(); k++) begin
                    if (pend[k].id == i) begin
                        ta[i]      = pend[k].a;
                        tb_b[i]    = pend[k].b;
                        cur_exp[i] = pend[k].e;
                        v[i]       = 1'b1;
                        pend.delete(k);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
        pend.push_back('{id: id, a: a, b: b, e: e});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pend.size() != 0 || v != 4'b0 || sb.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        res_ready = 1'b1;
        lat_chk = 1'b1;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = '0;
            tb_b[i] = '0;
            cur_exp[i] = '0;
        end
        step();
        v[0] = 1'b1;
        ta[0] = 16'h0003;
        tb_b[0] = 16'h0005;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        v[0] = 1'b0;
        rst = 1'b0;

        // Small operands, single transaction.
        grant_q.push_back(0);
        issue(0, 16'h0003, 16'h0005, 32'h0000000F);
        drain("small");

        // Top segment.
        grant_q.push_back(1);
        grant_q.push_back(1);
        issue(1, 16'hFFFF, 16'hFFFF, 32'hFF801000);
        issue(1, 16'h8000, 16'h8000, 32'h40000000);
        drain("top");

        // Middle segment, truncation visible.
        grant_q.push_back(2);
        grant_q.push_back(3);
        issue(2, 16'h07FF, 16'h0001, 32'h000007E0);
        issue(3, 16'h0400, 16'h0007, 32'h00001C00);
        drain("mid");

        // Fairness: all requesters contending.
        grant_q = '{0, 1, 2, 3, 0, 1};
        issue(0, 16'h0003, 16'h0005, 32'h0000000F);
        issue(1, 16'h0010, 16'h0010, 32'h00000100);
        issue(2, 16'h0400, 16'h0400, 32'h00100000);
        issue(3, 16'h8000, 16'h0002, 32'h00010000);
        issue(0, 16'h00FF, 16'h0100, 32'h0000FF00);
        issue(1, 16'hFFFF, 16'h0001, 32'h0000FFC0);
        drain("fair");
        chk("fair_grants_consumed", 32'(grant_q.size()), 32'd0);

        // Backpressure.
        lat_chk = 1'b0;
        issue(0, 16'h0002, 16'h0003, 32'h00000006);
        issue(1, 16'h0100, 16'h0100, 32'h00010000);
        issue(2, 16'h4000, 16'h0001, 32'h00004000);
        res_ready = 1'b0;
        step();
        step();
        step();
        chk("bp_full_req_ready", 32'(req_ready), 32'd0);
        chk("bp_pending_valid", 32'($countones(req_valid)), 32'd1);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        step();
        step();
        step();
        res_ready = 1'b1;
        drain("bp");

        // Mid-operation reset.
        issue(1, 16'h0001, 16'h0001, 32'h00000001);
        issue(2, 16'h0002, 16'h0002, 32'h00000004);
        res_ready = 1'b0;
        step();
        step();
        step();
        chk("mr_full_busy", 32'(busy), 32'd1);
        chk("mr_full_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_res_valid", 32'(res_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_res_data", res_data, 32'd0);
        chk("mr_res_id", 32'(res_id), 32'd0);
        grant_q.push_back(1);
        grant_q.push_back(3);
        issue(3, 16'h0005, 16'h0005, 32'h00000019);
        issue(1, 16'h0001, 16'h0009, 32'h00000009);
        res_ready = 1'b1;
        lat_chk = 1'b1;
        drain("mr");
        step();
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        chk("end_grant_q_empty", 32'(grant_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gessm_mul_arbiter.md
Name: gessm_mul_arbiter

Overview:
- Shares one approximate segmented 16x16 unsigned multiplier between NREQ requesters.
- The multiplier core is 10x10 with dynamic segmentation, the same arithmetic as the gESSM n16/m10/q5 datapath.
- Round-robin arbitration, 2-stage pipeline, valid/ready on both sides, result tagged with requester id.
- Sits between DSP accumulators and the single shared approximate multiplier slot.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of res_id; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request i has operands present.
- req_ready  out  NREQ  request i accepted this cycle; one-hot or zero.
- req_a  in  16*NREQ  operand a of requester i in bits [16i+15:16i].
- req_b  in  16*NREQ  operand b of requester i, packed the same way.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  approximate product.
- res_id  out  ID_W  index of the requester that issued the operands.
- busy  out  1  high when either pipeline stage holds data.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on rst.
- Reset values: res_valid=0, res_data=0, res_id=0, busy=0. Both stage-valid flags=0, round-robin pointer=0. req_ready=0 during the rst cycle.
- Segmentation, per 16-bit operand x:
  - If x[15]=1: seg=x[15:6], sh=6.
  - Else if x[14:10]!=0: seg=x[14:5], sh=5.
  - Else: seg=x[9:0], sh=0.
- Result = (seg_a*seg_b) << (sh_a+sh_b), truncated to 32 bits. No overflow is possible: max 0x3FF*0x3FF<<12 = 0xFF801000.
- Stage advance rules:
  - s2_adv = !s2_valid || res_ready.
  - s1_adv = !s1_valid || s2_adv.
- Arbitration (combinational):
  - Active only when s1_adv=1.
  - grant = first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NREQ.
  - req_ready[grant]=1; all other req_ready bits 0. All bits 0 if no valid or s1_adv=0.
- Handshake on req_valid[i] & req_ready[i]:
  - Stage 1 captures seg_a, seg_b, sh_a+sh_b and id=i; s1_valid=1.
  - ptr <= (i+1) mod NREQ.
- No handshake while s1_adv=1: s1_valid <= 0. ptr unchanged when no grant.
- Stage 2: on s2_adv, captures the shifted product and id from stage 1; s2_valid <= s1_valid.
- Outputs: res_valid=s2_valid; res_data and res_id are stage-2 registers.
- While res_valid & !res_ready, res_data and res_id hold stable.
- Latency: handshake at edge t gives res_valid at edge t+2 with no stall. Throughput is one result per cycle.
- Full pipeline (both stages valid) with res_ready=0: all req_ready=0, nothing is dropped.
- Simultaneous output pop and input accept in the same cycle is allowed; the pipeline flows.
- A requester holds req_valid and its operands until accepted. The block never depends on req_valid deasserting.
- busy = s1_valid | s2_valid.
- Reset mid-operation flushes both stages with no result emitted, and ptr returns to 0.

Test Plan:
- Small operands: req0 a=0x0003, b=0x0005, res_ready=1 -> req_ready[0]=1 at t; res_valid at t+2 with res_data=0x0000000F, res_id=0; one cycle only.
- Top segment: req1 a=0xFFFF, b=0xFFFF -> res_data=0xFF801000, res_id=1. Then a=0x8000, b=0x8000 -> 0x40000000.
- Middle segment, approximation visible: a=0x07FF, b=0x0001 -> 0x000007E0. Then a=0x0400, b=0x0007 -> 0x00001C00.
- Fairness: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; res_id follows the same order 2 cycles later.
- Backpressure: 3 back-to-back requests, then res_ready=0 for 4 cycles.
  - res_data/res_id stable throughout; all req_ready=0 once both stages are full.
  - After release, the 3 results arrive in order with no loss or duplication.
- Mid-operation reset: assert rst with both stages valid -> next cycle res_valid=0, busy=0, res_data=0. First grant afterwards goes to the lowest valid index counting from 0.
